// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end for the intersection controller: synchronizes and debounces the
// switches, latches per-lane requests, tracks waiting time and generates the step pulse.
module traffic_sensor_conditioner #(
    parameter int unsigned DB_COUNT     = 500000,
    parameter int unsigned DB_W         = 19,
    parameter int unsigned TICK_COUNT   = 50000000,
    parameter int unsigned TICK_W       = 26,
    parameter int unsigned STARVE_TICKS = 10
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [4:0] SW,
    input  logic [3:0] serve,
    output logic [3:0] req,
    output logic [3:0] starve,
    output logic       override,
    output logic       step
);
    localparam int unsigned NB = 5;
    localparam int unsigned NL = 4;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_COUNT - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_COUNT - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [3:0]        STARVE_TH = 4'(STARVE_TICKS);
    localparam logic [3:0]        WAIT_MAX  = 4'd15;

    logic [NB-1:0]     meta_q;
    logic [NB-1:0]     sync_q;
    logic [NB-1:0]     deb_q,  deb_d;
    logic [DB_W-1:0]   cnt_q  [NB];
    logic [DB_W-1:0]   cnt_d  [NB];
    logic [NL-1:0]     req_q,  req_d;
    logic [3:0]        wait_cnt_q [NL];
    logic [3:0]        wait_cnt_d [NL];
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              step_q, step_d;
    logic              ovr;

    assign ovr = deb_q[4];

    // Two-flop synchronizer; SW is asynchronous to CLOCK_50.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= SW;
            sync_q <= meta_q;
        end
    end

    // A single cycle of agreement restarts the count, so short glitches never reach deb_q.
    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < NB; k++) begin
            cnt_d[k] = '0;
            if (sync_q[k] != deb_q[k]) begin
                if (cnt_q[k] == DB_LAST) begin
                    deb_d[k] = sync_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + DB_ONE;
                end
            end
        end
    end

    always_comb begin
        req_d = req_q;
        if (ovr) begin
            req_d = '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (deb_q[i]) begin
                    req_d[i] = 1'b1;
                end else if (serve[i]) begin
                    req_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!req_q[i] || serve[i] || ovr) begin
                wait_cnt_d[i] = '0;
            end else if (step_q && (wait_cnt_q[i] != WAIT_MAX)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 4'd1;
            end
        end
    end

    // Prescaler keeps running under override so the controller can reach its safe state.
    always_comb begin
        step_d = (tick_q == TICK_LAST);
        tick_d = step_d ? '0 : tick_q + TICK_ONE;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            deb_q  <= '0;
            req_q  <= '0;
            tick_q <= '0;
            step_q <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                cnt_q[k] <= '0;
            end
            for (int i = 0; i < NL; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            deb_q  <= deb_d;
            req_q  <= req_d;
            tick_q <= tick_d;
            step_q <= step_d;
            for (int k = 0; k < NB; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            for (int i = 0; i < NL; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            starve[i] = (wait_cnt_q[i] >= STARVE_TH);
        end
    end

    assign req      = req_q;
    assign override = ovr;
    assign step     = step_q;

endmodule
